// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle CPU datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and selects, traps illegal instructions and counts retires.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [5:0]       OP,
    input  logic [5:0]       FUNCT,
    input  logic             zero,
    input  logic             overflow,
    output logic             PCWr,
    output logic             IRWr,
    output logic             MemWr,
    output logic             MemToReg,
    output logic             RegWr,
    output logic             RegDst,
    output logic             IsJAL,
    output logic             ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [2:0]       ALUctrl,
    output logic [1:0]       PCsrc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd7
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluXor = 3'b010;
    localparam logic [2:0] AluSlt = 3'b011;

    state_e           state_q, state_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic is_r, r_add, r_sub, r_slt, r_jr, r_arith;
    logic i_lw, i_sw, i_j, i_jal, i_beq, i_bne, i_addi, i_xori, legal;

    always_comb begin
        is_r    = (OP == 6'h00);
        r_add   = is_r && (FUNCT == 6'h20);
        r_sub   = is_r && (FUNCT == 6'h22);
        r_slt   = is_r && (FUNCT == 6'h2A);
        r_jr    = is_r && (FUNCT == 6'h08);
        r_arith = r_add || r_sub || r_slt;
        i_lw    = (OP == 6'h23);
        i_sw    = (OP == 6'h2B);
        i_j     = (OP == 6'h02);
        i_jal   = (OP == 6'h03);
        i_beq   = (OP == 6'h04);
        i_bne   = (OP == 6'h05);
        i_addi  = (OP == 6'h08);
        i_xori  = (OP == 6'h0E);
        legal   = r_arith || r_jr || i_lw || i_sw || i_j || i_jal || i_beq || i_bne ||
                  i_addi || i_xori;
    end

    always_comb begin
        state_d    = state_q;
        ovf_pend_d = ovf_pend_q;
        ovf_flag_d = ovf_flag_q;
        instret_d  = instret_q;
        retire     = 1'b0;
        case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = legal ? StExec : StHalt;
            StExec: begin
                if ((r_add || r_sub || i_addi) && overflow) begin
                    ovf_pend_d = 1'b1;
                    ovf_flag_d = 1'b1;
                end
                if (r_arith || i_addi || i_xori) state_d = StWb;
                else if (i_lw || i_sw)           state_d = StMem;
                else                             retire  = 1'b1;
            end
            StMem:    if (i_lw) state_d = StWb; else retire = 1'b1;
            StWb:     retire = 1'b1;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
        // run is only consulted here and in IDLE, so instructions always complete
        if (retire) begin
            state_d    = run ? StFetch : StIdle;
            instret_d  = instret_q + CNT_W'(1);
            ovf_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ovf_pend_q <= 1'b0;
            ovf_flag_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_flag_q <= ovf_flag_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        MemWr    = 1'b0;
        MemToReg = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        IsJAL    = 1'b0;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 2'd0;
        ALUctrl  = AluAdd;
        PCsrc    = 2'd0;
        case (state_q)
            StFetch: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                ALUsrcB = 2'd1;
            end
            StDecode: ALUsrcB = 2'd3;
            StExec: begin
                if (r_arith) begin
                    ALUsrcA = 1'b1;
                    ALUctrl = r_sub ? AluSub : (r_slt ? AluSlt : AluAdd);
                end else if (i_addi || i_lw || i_sw || i_xori) begin
                    ALUsrcA = 1'b1;
                    ALUsrcB = 2'd2;
                    ALUctrl = i_xori ? AluXor : AluAdd;
                end else if (i_beq || i_bne) begin
                    ALUsrcA = 1'b1;
                    ALUctrl = AluSub;
                    PCsrc   = 2'd1;
                    PCWr    = i_beq ? zero : !zero;
                end else if (i_j || i_jal) begin
                    PCWr    = 1'b1;
                    PCsrc   = 2'd2;
                    RegWr   = i_jal;
                    IsJAL   = i_jal;
                end else if (r_jr) begin
                    PCWr    = 1'b1;
                    PCsrc   = 2'd3;
                end
            end
            StMem: begin
                if (i_lw || i_sw) begin
                    ALUsrcA = 1'b1;
                    ALUsrcB = 2'd2;
                end
                MemWr = i_sw;
            end
            StWb: begin
                if (i_lw) begin
                    RegWr    = 1'b1;
                    MemToReg = 1'b1;
                end else if (r_arith) begin
                    RegWr  = !ovf_pend_q;
                    RegDst = 1'b1;
                end else if (i_addi) begin
                    RegWr  = !ovf_pend_q;
                end else if (i_xori) begin
                    RegWr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state    = state_q;
    assign halted   = (state_q == StHalt);
    assign ovf_flag = ovf_flag_q;
    assign instret  = instret_q;

endmodule
